bpsk_demodulator: RTL and testbench

BPSK_DEMODULATOR -- requirements
Module: bpsk_demodulator

---
 rtl/bpsk_demodulator.sv | 160 ++++++++++++++++
 tb/tb_bpsk_demodulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_demodulator
// Description : BPSK demodulator. Each symbol is one carrier period of
//               WAVELENGTH samples. A square-wave reference correlator adds
//               the first half-period and subtracts the second. The sign of
//               the sum gives the bit, and its magnitude gives a confidence
//               flag. Bits are packed MSB-first into bytes. An all-zero byte
//               ends the frame.
// Ports       : clock        - sole clock, rising edge
//               reset_n      - asynchronous active-low reset
//               flush        - synchronous clear of frame state
//               sample_valid - qualifies sample
//               sample       - signed carrier amplitude
//               bit_valid    - one-cycle pulse per decided symbol
//               bit_out      - decided bit (qualified by bit_valid)
//               bit_weak     - |sum| < THRESHOLD (qualified by bit_valid)
//               byte_valid   - one-cycle pulse per assembled byte
//               byte_out     - last assembled byte, held
//               frame_done   - high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_demodulator #(
    parameter int DATA_WIDTH = 8,
    parameter int WAVELENGTH = 16,
    parameter int THRESHOLD  = 64
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic                         bit_valid,
    output logic                         bit_out,
    output logic                         bit_weak,
    output logic                         byte_valid,
    output logic [7:0]                   byte_out,
    output logic                         frame_done
);

    localparam int IDX_W = $clog2(WAVELENGTH);
    localparam int ACC_W = DATA_WIDTH + IDX_W + 1;
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(WAVELENGTH - 1);
    localparam logic signed [ACC_W:0]   THRESH   = (ACC_W + 1)'(THRESHOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [7:0]                shreg_q, shreg_d;
    logic [7:0]                byte_q, byte_d;
    logic                      bit_valid_q, bit_valid_d;
    logic                      bit_out_q, bit_out_d;
    logic                      bit_weak_q, bit_weak_d;
    logic                      byte_valid_q, byte_valid_d;

    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W:0]     sum_wide;
    logic signed [ACC_W:0]     sum_mag;
    logic [7:0]                shreg_next;
    logic                      accept;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            byte_q       <= '0;
            bit_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_weak_q   <= 1'b0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            byte_q       <= byte_d;
            bit_valid_q  <= bit_valid_d;
            bit_out_q    <= bit_out_d;
            bit_weak_q   <= bit_weak_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        byte_d       = byte_q;
        bit_valid_d  = 1'b0;
        bit_out_d    = bit_out_q;
        bit_weak_d   = bit_weak_q;
        byte_valid_d = 1'b0;

        sample_ext = {{(ACC_W - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
        // WAVELENGTH is a power of two, so the index MSB marks the second
        // half-period, where the reference carrier is negative.
        sum        = idx_q[IDX_W-1] ? (acc_q - sample_ext) : (acc_q + sample_ext);
        // One extra bit keeps the negation of the most negative sum exact.
        sum_wide   = {sum[ACC_W-1], sum};
        sum_mag    = sum[ACC_W-1] ? -sum_wide : sum_wide;
        shreg_next = {shreg_q[6:0], sum[ACC_W-1]};
        accept     = sample_valid && (state_q != DONE);

        if (flush) begin
            // Flush wins over a coincident sample and kills any decision
            // that sample would have produced.
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                state_d = RUN;
            end
            if (idx_q == IDX_LAST) begin
                idx_d       = '0;
                acc_d       = '0;
                bit_valid_d = 1'b1;
                bit_out_d   = sum[ACC_W-1];
                bit_weak_d  = (sum_mag < THRESH);
                shreg_d     = shreg_next;
                cnt_d       = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    byte_d       = shreg_next;
                    byte_valid_d = 1'b1;
                    if (shreg_next == 8'h00) begin
                        state_d = DONE;
                    end
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
                acc_d = sum;
            end
        end
    end

    assign bit_valid  = bit_valid_q;
    assign bit_out    = bit_out_q;
    assign bit_weak   = bit_weak_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_q;
    assign frame_done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bpsk_demodulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_demodulator
// Description : Scoreboard bench for bpsk_demodulator. Stimulus tasks push
//               the expected bit/byte events into a queue. A monitor pops
//               and compares them on every bit_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_demodulator;

    localparam int W  = 16;
    localparam int TH = 64;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              sample_valid;
    logic signed [7:0] sample;
    logic              bit_valid, bit_out, bit_weak, byte_valid, frame_done;
    logic [7:0]        byte_out;

    bpsk_demodulator #(.DATA_WIDTH(8), .WAVELENGTH(W), .THRESHOLD(TH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .sample_valid (sample_valid),
        .sample       (sample),
        .bit_valid    (bit_valid),
        .bit_out      (bit_out),
        .bit_weak     (bit_weak),
        .byte_valid   (byte_valid),
        .byte_out     (byte_out),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       b;
        logic       w;
        logic       bv;
        logic [7:0] by;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         total  = 0;
    int         bad    = 0;
    int         nbytes = 0;

    // Bench-side byte assembly model
    int         m_cnt  = 0;
    logic [7:0] m_sh   = 8'h00;
    bit         m_done = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_sh   = 8'h00;
        m_done = 1'b0;
    endtask

    // Monitor: compare every bit_valid against the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bit_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_bit_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("bit_out", int'(bit_out), int'(e.b));
                    chk("bit_weak", int'(bit_weak), int'(e.w));
                    chk("byte_valid", int'(byte_valid), int'(e.bv));
                    if (e.bv) chk("byte_out", int'(byte_out), int'(e.by));
                end
            end else if (byte_valid) begin
                chk("stray_byte_valid", 1, 0);
            end
            if (byte_valid) nbytes++;
        end
    end

    // One symbol: first half-period +s, second half -s, with s = amp for
    // bit 0 and s = -amp for bit 1.
    task automatic send_bit(input logic b, input int amp, input bit gaps);
        int   s;
        int   sum;
        bit   pulse;
        exp_t x;
        sum = 0;
        for (int i = 0; i < W; i++) begin
            s = (i < W/2) ? amp : -amp;
            if (b) s = -s;
            sum += (i < W/2) ? s : -s;
        end
        pulse = !m_done;
        if (pulse) begin
            x.b  = (sum < 0);
            x.w  = ((sum < 0 ? -sum : sum) < TH);
            m_sh = {m_sh[6:0], x.b};
            m_cnt++;
            x.bv = (m_cnt == 8);
            x.by = m_sh;
            if (m_cnt == 8) begin
                m_cnt = 0;
                if (m_sh == 8'h00) m_done = 1'b1;
            end
            q.push_back(x);
        end
        for (int i = 0; i < W; i++) begin
            if (gaps) begin
                sample_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            s = (i < W/2) ? amp : -amp;
            if (b) s = -s;
            sample_valid = 1'b1;
            sample       = 8'(s);
            tick();
        end
        sample_valid = 1'b0;
        chk("bit_latency", int'(bit_valid), int'(pulse));
    endtask

    task automatic send_byte(input logic [7:0] by, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(by[i], 64, gaps);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bit_valid"},  int'(bit_valid),  0);
        chk({tag, "_bit_out"},    int'(bit_out),    0);
        chk({tag, "_bit_weak"},   int'(bit_weak),   0);
        chk({tag, "_byte_valid"}, int'(byte_valid), 0);
        chk({tag, "_byte_out"},   int'(byte_out),   0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        flush        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        repeat (2) tick();
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        tick();

        // Strong +1024, strong -1024, then all-zero weak symbol
        send_bit(1'b0, 64, 1'b0);
        send_bit(1'b1, 64, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        repeat (2) tick();
        do_flush();

        // Flush coincident with the index-10 sample drops the partial symbol
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1;
            sample       = 8'sd64;
            tick();
        end
        sample_valid = 1'b1;
        sample       = -8'sd64;
        flush        = 1'b1;
        tick();
        sample_valid = 1'b0;
        flush        = 1'b0;
        model_clear();
        repeat (3) tick();
        send_bit(1'b1, 64, 1'b0);
        repeat (2) tick();
        do_flush();

        // Frame: 0x48, 0x69, 0x00 with random gaps, then ignored symbols
        nbytes = 0;
        send_byte(8'h48, 1'b1);
        send_byte(8'h69, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("frame_done_set", int'(frame_done), 1);
        send_bit(1'b1, 64, 1'b0);
        send_bit(1'b0, 64, 1'b0);
        repeat (2) tick();
        chk("frame_done_hold", int'(frame_done), 1);
        chk("byte_count", nbytes, 3);
        chk("byte_out_hold", int'(byte_out), 0);
        do_flush();
        chk("frame_done_flush", int'(frame_done), 0);

        // Reset mid-byte after 5 bits, with a partial symbol in flight
        send_byte(8'hFF, 1'b0);
        chk("byte_out_ff", int'(byte_out), 8'hFF);
        send_bit(1'b1, 64, 1'b0);
        send_bit(1'b0, 64, 1'b0);
        send_bit(1'b1, 64, 1'b0);
        send_bit(1'b1, 64, 1'b0);
        send_bit(1'b0, 64, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample       = 8'sd64;
            tick();
        end
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        #2;
        chk_outputs_zero("midreset");
        tick();
        reset_n = 1'b1;
        model_clear();
        tick();
        chk_outputs_zero("postreset");
        nbytes = 0;
        send_byte(8'hA5, 1'b0);
        repeat (3) tick();
        chk("byte_out_a5", int'(byte_out), 8'hA5);
        chk("byte_count_a5", nbytes, 1);
        chk("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
